// File: rtl/press_train_tx.sv
`default_nettype none
// ============================================================================
// Module      : press_train_tx
// Description : Button-press emulator. Latches a press count on start and
//               emits that many clean press/release pulses on btn_out, with
//               press and gap lengths long enough to survive a downstream
//               synchronizer and debounce filter. Optional abort ends the
//               train early, always leaving a full trailing low period.
// Revision    : 1.0 - initial release
// ============================================================================
module press_train_tx #(
    parameter int CNT_W        = 6,
    parameter int PRESS_CYCLES = 131072,
    parameter int GAP_CYCLES   = 131072,
    parameter int TMR_W        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             ready,
    output logic             btn_out,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS     = 3'd1,
        S_GAP       = 3'd2,
        S_FINAL_GAP = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Timer reload values: the timer counts down to zero, so a phase of
    // N cycles is loaded with N-1.
    localparam logic [TMR_W-1:0] c_press_load = TMR_W'(PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_gap_load   = TMR_W'(GAP_CYCLES - 1);

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_count;

    // Phase sequencer; every output is computed alongside the next state so
    // it changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_count     <= '0;
            ready       <= 1'b1;
            btn_out     <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            pulses_sent <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count     <= count;
                        pulses_sent <= '0;
                        aborted     <= 1'b0;
                        ready       <= 1'b0;
                        if (count != '0) begin
                            r_state <= S_PRESS;
                            r_timer <= c_press_load;
                            btn_out <= 1'b1;
                        end else begin
                            // Zero-length train: report completion with no press.
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end

                S_PRESS: begin
                    if (abort) begin
                        // Abort wins over the final-cycle increment, so a
                        // truncated press is never counted.
                        r_state <= S_FINAL_GAP;
                        r_timer <= c_gap_load;
                        btn_out <= 1'b0;
                        aborted <= 1'b1;
                    end else if (r_timer == '0) begin
                        pulses_sent <= pulses_sent + CNT_W'(1);
                        r_state     <= S_GAP;
                        r_timer     <= c_gap_load;
                        btn_out     <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        r_state <= S_FINAL_GAP;
                        r_timer <= c_gap_load;
                        aborted <= 1'b1;
                    end else if (r_timer == '0) begin
                        if (pulses_sent == r_count) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_PRESS;
                            r_timer <= c_press_load;
                            btn_out <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_FINAL_GAP: begin
                    // Trailing low so the receiver sees a settled release.
                    if (r_timer == '0) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    ready   <= 1'b1;
                    btn_out <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
